trace_capture: RTL and testbench
================================

Name: trace_capture

Overview:
Synthesizable, parametrised replacement for the per-clock register/IR print-out in the CPU bench. It snapshots NUM_CH probe words (IR, registers, mem[0], ...) into an on-chip circular buffer on qualified cycles. Capture either fills the buffer or runs with a trigger and post-trigger window. It then drains the captured samples oldest-first over a valid/ready port, so the same trace works in simulation and on hardware.

Parameters:
DATA_W, 16, width of one probe channel (CPU word width)
NUM_CH, 4, number of probe channels captured per sample
DEPTH, 16, buffer entries; power of two, >= 2
POST, 4, samples captured after trigger in trigger mode; 0..DEPTH-1

Ports:
clk  in  1  single clock; all logic on rising edge
rst  in  1  synchronous, active-high reset
arm  in  1  start a capture; honoured only in IDLE
mode  in  1  0 = fill mode, 1 = trigger mode; sampled when arm is accepted
sample_en  in  1  qualifies the current cycle's probe data for capture
trig  in  1  trigger event; used only in trigger mode, CAPTURE state
ch_data  in  NUM_CH*DATA_W  probe words; channel k at bits [k*DATA_W +: DATA_W]
rd_valid  out  1  readout beat available
rd_ready  in  1  consumer accepts beat
rd_data  out  NUM_CH*DATA_W  one captured sample
rd_last  out  1  high with the final beat of a drain
busy  out  1  high in any state other than IDLE
triggered  out  1  trigger seen in the current or last capture
count  out  $clog2(DEPTH)+1  valid entries held, saturating at DEPTH

Behaviour:
- States: IDLE, CAPTURE, POST, DRAIN.
- Reset (rst=1 at a clock edge):
  - State goes to IDLE.
  - wr_ptr, rd_ptr, post counter and count clear to 0.
  - rd_valid, rd_last, busy and triggered clear to 0; rd_data clears to 0.
  - Buffer RAM contents are not cleared.
  - Reset mid-capture or mid-drain aborts immediately; no further beats are issued.
- IDLE:
  - arm=1 latches mode, clears wr_ptr, count and triggered, and moves to CAPTURE.
  - No sample is written in the arm cycle.
- Write rule (CAPTURE and POST):
  - On each cycle with sample_en=1, ch_data is written at wr_ptr.
  - wr_ptr increments modulo DEPTH.
  - count increments, saturating at DEPTH.
- CAPTURE, mode 0 (fill):
  - trig is ignored.
  - Move to DRAIN on the edge where the write makes count equal DEPTH.
- CAPTURE, mode 1 (trigger):
  - Writing is circular; oldest entries are overwritten.
  - trig=1 sets triggered. The same-cycle sample is written if sample_en=1 and counts as pre-trigger.
  - With POST>0, load the post counter with POST and move to POST.
  - With POST=0, move to DRAIN.
- POST:
  - Each write decrements the post counter.
  - The write that takes it to 0 moves the block to DRAIN.
  - Further trig pulses are ignored.
  - With sample_en held 0, the block stays in POST indefinitely.
- DRAIN entry:
  - rd_ptr = wr_ptr if count==DEPTH, else 0 (oldest first).
  - Beats remaining = count.
  - If count==0, return to IDLE next cycle with no beats.
- DRAIN:
  - rd_valid rises 1 cycle after entry and stays high until the last beat transfers.
  - rd_data is registered, loaded from the buffer, and held stable while rd_valid=1 and rd_ready=0.
  - A beat transfers when rd_valid and rd_ready are both high at a clock edge. rd_ptr then advances modulo DEPTH and the next sample appears the following cycle.
  - Back-to-back beats at one per cycle are required when rd_ready is held high.
  - rd_last=1 exactly with the final beat.
  - After it transfers: rd_valid=0, state IDLE, count holds its final value until the next arm.
- arm outside IDLE is ignored. sample_en and trig in DRAIN are ignored; nothing is written.
- Channel k of rd_data corresponds bit-exactly to channel k of ch_data at capture time.

Test Plan:
- Fill mode: DEPTH=8, NUM_CH=2, DATA_W=16. Arm with mode=0, 10 samples ch_data={k,16'hA000+k} for k=0..9 with sample_en every cycle -> DRAIN after sample 7; 8 beats k=0..7; rd_last on k=7; count=8.
- Trigger mode: POST=3. Write k=0..11, trig on k=6 -> writes stop after k=9; 8 beats k=2..9; triggered=1; rd_last on k=9.
- Partial buffer: mode=1, POST=0, trig on 3rd sample (k=2) -> DRAIN with count=3; beats k=0,1,2 starting at entry 0.
- Backpressure: during drain, rd_ready toggles 1,0,0,1,... -> rd_data unchanged while stalled; no beat lost or duplicated; order intact.
- sample_en gaps: assert sample_en on alternate cycles in fill mode -> only qualified cycles captured; unqualified data never appears in readout.
- Reset mid-operation: rst=1 during POST and again during DRAIN beat 3 -> next cycle IDLE, rd_valid=0, count=0, busy=0; a fresh arm captures correctly.

Source files
------------

// File: rtl/trace_capture.sv
// Trace capture buffer: snapshots NUM_CH probe words into a circular RAM on
// qualified cycles (fill or trigger/post-trigger window) and drains them oldest-first.
module trace_capture #(
    parameter int DATA_W = 16,
    parameter int NUM_CH = 4,
    parameter int DEPTH  = 16,
    parameter int POST   = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       arm,
    input  logic                       mode,
    input  logic                       sample_en,
    input  logic                       trig,
    input  logic [NUM_CH*DATA_W-1:0]   ch_data,
    output logic                       rd_valid,
    input  logic                       rd_ready,
    output logic [NUM_CH*DATA_W-1:0]   rd_data,
    output logic                       rd_last,
    output logic                       busy,
    output logic                       triggered,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int W  = NUM_CH * DATA_W;
    localparam logic [CW-1:0] FULL    = CW'(DEPTH);
    localparam logic [AW-1:0] POST_LD = AW'(POST);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_CAPTURE = 2'd1,
        S_POST    = 2'd2,
        S_DRAIN   = 2'd3
    } state_t;

    state_t          state_r, state_next_s;
    logic            mode_r;
    logic [AW-1:0]   wr_ptr_r, rd_ptr_r, post_cnt_r;
    logic [CW-1:0]   count_r, beats_r;
    logic            rd_valid_r, rd_last_r, busy_r, triggered_r;
    logic [W-1:0]    rd_data_r;
    logic [W-1:0]    mem_r [DEPTH];

    logic            wr_en_s, xfer_s, load_s, drain_entry_s, trig_hit_s;
    logic [AW-1:0]   wr_ptr_new_s;
    logic [CW-1:0]   count_new_s;

    // Next-state decode and datapath control strobes
    always_comb begin
        state_next_s  = state_r;
        wr_en_s       = sample_en && !rst && ((state_r == S_CAPTURE) || (state_r == S_POST));
        xfer_s        = rd_valid_r && rd_ready;
        load_s        = (state_r == S_DRAIN) && (!rd_valid_r || xfer_s) && (beats_r != {CW{1'b0}});
        trig_hit_s    = (state_r == S_CAPTURE) && mode_r && trig;
        wr_ptr_new_s  = wr_ptr_r;
        count_new_s   = count_r;
        drain_entry_s = 1'b0;

        if (wr_en_s) begin
            wr_ptr_new_s = wr_ptr_r + AW'(1);
        end else begin
            wr_ptr_new_s = wr_ptr_r;
        end
        if (wr_en_s && (count_r != FULL)) begin
            count_new_s = count_r + CW'(1);
        end else begin
            count_new_s = count_r;
        end

        case (state_r)
            S_IDLE: begin
                if (arm) begin
                    state_next_s = S_CAPTURE;
                end else begin
                    state_next_s = S_IDLE;
                end
            end
            S_CAPTURE: begin
                if (!mode_r) begin
                    if (wr_en_s && (count_new_s == FULL)) begin
                        state_next_s = S_DRAIN;
                    end else begin
                        state_next_s = S_CAPTURE;
                    end
                end else if (trig) begin
                    state_next_s = (POST == 0) ? S_DRAIN : S_POST;
                end else begin
                    state_next_s = S_CAPTURE;
                end
            end
            S_POST: begin
                if (wr_en_s && (post_cnt_r == AW'(1))) begin
                    state_next_s = S_DRAIN;
                end else begin
                    state_next_s = S_POST;
                end
            end
            S_DRAIN: begin
                if ((xfer_s && rd_last_r) || (!rd_valid_r && (beats_r == {CW{1'b0}}))) begin
                    state_next_s = S_IDLE;
                end else begin
                    state_next_s = S_DRAIN;
                end
            end
            default: state_next_s = S_IDLE;
        endcase

        drain_entry_s = (state_next_s == S_DRAIN) && (state_r != S_DRAIN);
    end

    // Capture RAM write port; contents deliberately survive reset
    always_ff @(posedge clk) begin
        if (wr_en_s) begin
            mem_r[wr_ptr_r] <= ch_data;
        end
    end

    // State register and capture-side bookkeeping
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= S_IDLE;
            busy_r      <= 1'b0;
            mode_r      <= 1'b0;
            wr_ptr_r    <= {AW{1'b0}};
            count_r     <= {CW{1'b0}};
            post_cnt_r  <= {AW{1'b0}};
            triggered_r <= 1'b0;
        end else begin
            state_r <= state_next_s;
            busy_r  <= (state_next_s != S_IDLE);
            if ((state_r == S_IDLE) && arm) begin
                mode_r      <= mode;
                wr_ptr_r    <= {AW{1'b0}};
                count_r     <= {CW{1'b0}};
                triggered_r <= 1'b0;
            end else begin
                wr_ptr_r <= wr_ptr_new_s;
                count_r  <= count_new_s;
                if (trig_hit_s) begin
                    triggered_r <= 1'b1;
                end
            end
            // The trigger-cycle write counts as pre-trigger, so the window starts after it
            if (trig_hit_s) begin
                post_cnt_r <= POST_LD;
            end else if ((state_r == S_POST) && wr_en_s) begin
                post_cnt_r <= post_cnt_r - AW'(1);
            end
        end
    end

    // Readout side: rd_ptr_r always points at the next entry to load into rd_data_r
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr_r   <= {AW{1'b0}};
            beats_r    <= {CW{1'b0}};
            rd_valid_r <= 1'b0;
            rd_last_r  <= 1'b0;
            rd_data_r  <= {W{1'b0}};
        end else if (drain_entry_s) begin
            rd_ptr_r <= (count_new_s == FULL) ? wr_ptr_new_s : {AW{1'b0}};
            beats_r  <= count_new_s;
        end else if (load_s) begin
            rd_data_r  <= mem_r[rd_ptr_r];
            rd_ptr_r   <= rd_ptr_r + AW'(1);
            beats_r    <= beats_r - CW'(1);
            rd_valid_r <= 1'b1;
            rd_last_r  <= (beats_r == CW'(1));
        end else if (xfer_s) begin
            rd_valid_r <= 1'b0;
            rd_last_r  <= 1'b0;
        end
    end

    assign rd_valid  = rd_valid_r;
    assign rd_data   = rd_data_r;
    assign rd_last   = rd_last_r;
    assign busy      = busy_r;
    assign triggered = triggered_r;
    assign count     = count_r;

endmodule

// File: tb/tb_trace_capture.sv
// Directed bench for trace_capture: DEPTH=8, NUM_CH=2, DATA_W=16; a second
// instance with POST=0 covers the partial-buffer trigger case.
module tb_trace_capture;

    localparam int DW = 16;
    localparam int NC = 2;
    localparam int DP = 8;
    localparam int W  = NC * DW;
    localparam int CW = $clog2(DP) + 1;

    logic          clk, rst, arm0, arm1, mode, sample_en, trig;
    logic [W-1:0]  ch_data;
    logic          rd_ready0, rd_ready1;
    logic          rd_valid0, rd_valid1, rd_last0, rd_last1;
    logic          busy0, busy1, triggered0, triggered1;
    logic [W-1:0]  rd_data0, rd_data1;
    logic [CW-1:0] count0, count1;

    int n_checks = 0;
    int n_errors = 0;
    logic [W-1:0] exp_q[$];

    trace_capture #(.DATA_W(DW), .NUM_CH(NC), .DEPTH(DP), .POST(3)) dut0 (
        .clk(clk), .rst(rst), .arm(arm0), .mode(mode), .sample_en(sample_en),
        .trig(trig), .ch_data(ch_data), .rd_valid(rd_valid0), .rd_ready(rd_ready0),
        .rd_data(rd_data0), .rd_last(rd_last0), .busy(busy0),
        .triggered(triggered0), .count(count0)
    );

    trace_capture #(.DATA_W(DW), .NUM_CH(NC), .DEPTH(DP), .POST(0)) dut1 (
        .clk(clk), .rst(rst), .arm(arm1), .mode(mode), .sample_en(sample_en),
        .trig(trig), .ch_data(ch_data), .rd_valid(rd_valid1), .rd_ready(rd_ready1),
        .rd_data(rd_data1), .rd_last(rd_last1), .busy(busy1),
        .triggered(triggered1), .count(count1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [W-1:0] mk(input int k);
        logic [15:0] kk;
        kk = k[15:0];
        return {kk, 16'hA000 + kk};
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic feed(input int k, input bit en, input bit tg);
        ch_data   = en ? mk(k) : (32'hDEAD_0000 | 32'(k));
        sample_en = en;
        trig      = tg;
        step();
    endtask

    task automatic arm_dut(input bit sel, input bit md);
        mode = md;
        if (sel) arm1 = 1'b1; else arm0 = 1'b1;
        sample_en = 1'b0;
        trig      = 1'b0;
        step();
        arm0 = 1'b0;
        arm1 = 1'b0;
    endtask

    // Consume beats until stop_at have been accepted; every valid cycle must show exp_q[got]
    task automatic drain(input bit sel, input bit bp, input int stop_at);
        int got = 0;
        int cyc = 0;
        int n;
        logic v, l, r;
        logic [W-1:0] d;
        n = exp_q.size();
        sample_en = 1'b0;
        trig      = 1'b0;
        while (got < stop_at && cyc < 300) begin
            v = sel ? rd_valid1 : rd_valid0;
            l = sel ? rd_last1 : rd_last0;
            d = sel ? rd_data1 : rd_data0;
            r = bp ? (cyc % 3 == 0) : 1'b1;
            if (sel) rd_ready1 = r; else rd_ready0 = r;
            if (v) begin
                check("beat_data", d, exp_q[got]);
                check("beat_last", l, got == n - 1);
                if (r) got++;
            end
            step();
            cyc++;
        end
        rd_ready0 = 1'b0;
        rd_ready1 = 1'b0;
        if (got < stop_at) check("drain_timeout", got, stop_at);
    endtask

    initial begin
        rst = 1'b1; arm0 = 1'b0; arm1 = 1'b0; mode = 1'b0; sample_en = 1'b0;
        trig = 1'b0; ch_data = '0; rd_ready0 = 1'b0; rd_ready1 = 1'b0;
        step();
        step();
        check("rst_valid", rd_valid0, 1'b0);
        check("rst_busy", busy0, 1'b0);
        check("rst_count", count0, 0);
        check("rst_trig", triggered0, 1'b0);
        check("rst_data", rd_data0, 0);
        check("rst_last", rd_last0, 1'b0);
        rst = 1'b0;
        step();

        // Fill mode: trig must be ignored, capture stops at 8 samples
        arm_dut(1'b0, 1'b0);
        check("arm_busy", busy0, 1'b1);
        for (int k = 0; k < 10; k++) feed(k, 1'b1, k == 3);
        check("fill_count", count0, 8);
        check("fill_trig", triggered0, 1'b0);
        exp_q.delete();
        for (int k = 0; k < 8; k++) exp_q.push_back(mk(k));
        drain(1'b0, 1'b0, 8);
        check("fill_end_valid", rd_valid0, 1'b0);
        check("fill_end_busy", busy0, 1'b0);
        check("fill_end_count", count0, 8);

        // Trigger mode with POST=3, trig on sample 6
        arm_dut(1'b0, 1'b1);
        check("arm_clr_count", count0, 0);
        for (int k = 0; k < 12; k++) feed(k, 1'b1, k == 6);
        check("trig_flag", triggered0, 1'b1);
        check("trig_count", count0, 8);
        exp_q.delete();
        for (int k = 2; k < 10; k++) exp_q.push_back(mk(k));
        drain(1'b0, 1'b0, 8);
        check("trig_end_valid", rd_valid0, 1'b0);
        check("trig_end_flag", triggered0, 1'b1);

        // Partial buffer on the POST=0 instance
        arm_dut(1'b1, 1'b1);
        for (int k = 0; k < 3; k++) feed(k, 1'b1, k == 2);
        check("part_count", count1, 3);
        check("part_busy", busy1, 1'b1);
        check("part_trig", triggered1, 1'b1);
        check("part_other_idle", busy0, 1'b0);
        exp_q.delete();
        for (int k = 0; k < 3; k++) exp_q.push_back(mk(k));
        drain(1'b1, 1'b0, 3);
        check("part_end_valid", rd_valid1, 1'b0);
        check("part_end_busy", busy1, 1'b0);

        // sample_en gaps plus backpressure 1,0,0 during drain
        arm_dut(1'b0, 1'b0);
        for (int k = 0; k < 16; k++) feed(k, (k % 2) == 0, 1'b0);
        check("gap_count", count0, 8);
        exp_q.delete();
        for (int k = 0; k < 16; k += 2) exp_q.push_back(mk(k));
        drain(1'b0, 1'b1, 8);
        check("gap_end_valid", rd_valid0, 1'b0);
        check("gap_end_busy", busy0, 1'b0);

        // Reset during POST
        arm_dut(1'b0, 1'b1);
        for (int k = 0; k < 7; k++) feed(k, 1'b1, k == 5);
        check("post_busy", busy0, 1'b1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("rstp_busy", busy0, 1'b0);
        check("rstp_valid", rd_valid0, 1'b0);
        check("rstp_count", count0, 0);
        check("rstp_trig", triggered0, 1'b0);

        // Reset during drain after three beats
        arm_dut(1'b0, 1'b0);
        for (int k = 20; k < 28; k++) feed(k, 1'b1, 1'b0);
        exp_q.delete();
        for (int k = 20; k < 28; k++) exp_q.push_back(mk(k));
        drain(1'b0, 1'b0, 3);
        rd_ready0 = 1'b1;
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("rstd_valid", rd_valid0, 1'b0);
        check("rstd_busy", busy0, 1'b0);
        check("rstd_count", count0, 0);
        for (int i = 0; i < 4; i++) begin
            step();
            check("rstd_quiet", rd_valid0, 1'b0);
        end
        rd_ready0 = 1'b0;

        // Fresh capture after the abort
        arm_dut(1'b0, 1'b0);
        for (int k = 30; k < 38; k++) feed(k, 1'b1, 1'b0);
        check("fresh_count", count0, 8);
        exp_q.delete();
        for (int k = 30; k < 38; k++) exp_q.push_back(mk(k));
        drain(1'b0, 1'b1, 8);
        check("fresh_end_valid", rd_valid0, 1'b0);
        check("fresh_end_busy", busy0, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
